// File: rtl/custom_adder_seq.sv
// Multi-cycle A +/- zext(B), CHUNK bits per RUN cycle with ripple carry; one RUN cycle per chunk, early exit once B is consumed.
// Valid/ready on both sides; accepts in IDLE only and holds the result in DONE until out_ready.
module custom_adder_seq #(
  parameter int A_WIDTH    = 55,
  parameter int B_WIDTH    = 7,
  parameter int CHUNK      = 8,
  parameter int EARLY_EXIT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [A_WIDTH-1:0] a,
  input  logic [B_WIDTH-1:0] b,
  input  logic               sub,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [A_WIDTH:0]   sum
);

  localparam int NCHUNK = (A_WIDTH + CHUNK - 1) / CHUNK;
  localparam int NB     = (B_WIDTH + CHUNK - 1) / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [A_WIDTH-1:0] ONES = '1;
  localparam logic [A_WIDTH:0]   ONE  = (A_WIDTH+1)'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t state;
  state_t state_next;

  logic [A_WIDTH-1:0] a_r;
  logic [B_WIDTH-1:0] b_r;
  logic               sub_r;
  logic               carry_r;
  logic [IDXW-1:0]    idx_r;
  logic [A_WIDTH:0]   sum_r;

  logic [A_WIDTH-1:0] bx;
  logic [A_WIDTH-1:0] low_w;
  logic [A_WIDTH-1:0] chunk_mask;
  logic [A_WIDTH-1:0] cum_mask;
  logic [A_WIDTH-1:0] sa;
  logic [A_WIDTH-1:0] sb;
  logic [A_WIDTH-1:0] sum_chunk;
  logic [A_WIDTH-1:0] sum_final;
  logic [A_WIDTH:0]   s;
  logic [31:0]        off;
  logic [31:0]        w;
  logic               carry_next;
  logic               last;

  // Chunk idx is isolated with masks so the narrower final chunk needs no special datapath.
  assign bx         = sub_r ? ~A_WIDTH'(b_r) : A_WIDTH'(b_r);
  assign off        = 32'(idx_r) * 32'(CHUNK);
  assign w          = (32'(A_WIDTH) - off < 32'(CHUNK)) ? 32'(A_WIDTH) - off : 32'(CHUNK);
  assign low_w      = ~(ONES << w);
  assign chunk_mask = low_w << off;
  assign cum_mask   = ~(ONES << (off + w));
  assign sa         = (a_r >> off) & low_w;
  assign sb         = (bx >> off) & low_w;
  assign s          = {1'b0, sa} + {1'b0, sb} + {{A_WIDTH{1'b0}}, carry_r};
  assign carry_next = |(s & (ONE << w));
  assign sum_chunk  = (sum_r[A_WIDTH-1:0] & ~chunk_mask) | ((s[A_WIDTH-1:0] << off) & chunk_mask);
  // Above the last processed chunk the carry equals sub, so A passes through unchanged.
  assign sum_final  = (sum_chunk & cum_mask) | (a_r & ~cum_mask);
  assign last       = (idx_r == IDXW'(NCHUNK - 1)) ||
                      ((EARLY_EXIT != 0) && (32'(idx_r) + 32'd1 >= 32'(NB)) && (carry_next == sub_r));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = RUN;
      RUN:     if (last)      state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r     <= '0;
      b_r     <= '0;
      sub_r   <= 1'b0;
      carry_r <= 1'b0;
      idx_r   <= '0;
      sum_r   <= '0;
    end else if (state == IDLE && in_valid) begin
      a_r     <= a;
      b_r     <= b;
      sub_r   <= sub;
      carry_r <= sub;
      idx_r   <= '0;
    end else if (state == RUN) begin
      if (last) begin
        sum_r <= {carry_next ^ sub_r, sum_final};
      end else begin
        sum_r[A_WIDTH-1:0] <= sum_chunk;
        idx_r              <= IDXW'(32'(idx_r) + 32'd1);
        carry_r            <= carry_next;
      end
    end
  end

  assign sum = sum_r;

endmodule

// File: tb/tb_custom_adder_seq.sv
// Bench for custom_adder_seq: an early-exit and a full-length instance share inputs and are
// checked against arithmetic expectations for result and latency.
module tb_custom_adder_seq;

  localparam int AW = 55;
  localparam int BW = 7;
  localparam int CH = 8;
  localparam int NCHUNK = (AW + CH - 1) / CH;
  localparam int NB = (BW + CH - 1) / CH;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [AW-1:0] a = '0;
  logic [BW-1:0] b = '0;
  logic          sub = 1'b0;
  logic          out_ready = 1'b0;
  logic          in_ready1, out_valid1, in_ready0, out_valid0;
  logic [AW:0]   sum1, sum0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  custom_adder_seq #(.A_WIDTH(AW), .B_WIDTH(BW), .CHUNK(CH), .EARLY_EXIT(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1), .a(a), .b(b),
    .sub(sub), .out_valid(out_valid1), .out_ready(out_ready), .sum(sum1));

  custom_adder_seq #(.A_WIDTH(AW), .B_WIDTH(BW), .CHUNK(CH), .EARLY_EXIT(0)) dut_ne (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0), .a(a), .b(b),
    .sub(sub), .out_valid(out_valid0), .out_ready(out_ready), .sum(sum0));

  // Exact result from plain arithmetic; bit AW of the AW+1-bit difference is the borrow.
  function automatic logic [AW:0] exp_sum(input logic [AW-1:0] ta, input logic [BW-1:0] tb, input logic ts);
    logic [AW:0] ea, eb;
    ea = {1'b0, ta};
    eb = (AW+1)'(tb);
    return ts ? ea - eb : ea + eb;
  endfunction

  // Fewest whole chunks covering B after which no carry/borrow leaves the low part.
  function automatic int exp_k(input logic [AW-1:0] ta, input logic [BW-1:0] tb, input logic ts);
    longint unsigned av, bv, m, lo;
    av = 64'(ta);
    bv = 64'(tb);
    for (int j = NB; j < NCHUNK; j++) begin
      m  = 64'd1 << (CH * j);
      lo = av % m;
      if (ts ? (lo >= bv) : (lo + bv < m)) return j;
    end
    return NCHUNK;
  endfunction

  // Issues one operation to both instances and measures each one's result and latency.
  task automatic run_op(input logic [AW-1:0] ta, input logic [BW-1:0] tb, input logic ts,
                        output logic [AW:0] s1, output int k1, output logic [AW:0] s0, output int k0);
    @(negedge clk);
    a = ta; b = tb; sub = ts; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    k1 = -1; k0 = -1; s1 = '0; s0 = '0;
    for (int c = 1; c <= 20 && (k1 < 0 || k0 < 0); c++) begin
      @(posedge clk); #1;
      if (out_valid1 && k1 < 0) begin k1 = c; s1 = sum1; end
      if (out_valid0 && k0 < 0) begin k0 = c; s0 = sum0; end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    checks += 6;
    if (in_ready1 !== 1'b1)  begin errors++; $display("FAIL reset_in_ready1 got %b want 1", in_ready1); end
    if (out_valid1 !== 1'b0) begin errors++; $display("FAIL reset_out_valid1 got %b want 0", out_valid1); end
    if (sum1 !== '0)         begin errors++; $display("FAIL reset_sum1 got %h want 0", sum1); end
    if (in_ready0 !== 1'b1)  begin errors++; $display("FAIL reset_in_ready0 got %b want 1", in_ready0); end
    if (out_valid0 !== 1'b0) begin errors++; $display("FAIL reset_out_valid0 got %b want 0", out_valid0); end
    if (sum0 !== '0)         begin errors++; $display("FAIL reset_sum0 got %h want 0", sum0); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed;
    logic [AW-1:0] ta [4];
    logic [BW-1:0] tbv [4];
    logic          tsv [4];
    logic [AW:0]   es [4];
    int            ek [4];
    logic [AW:0]   s1, s0;
    int            k1, k0;
    ta  = '{55'd100, 55'h7F_FFFF_FFFF_FFFF, 55'd5, 55'h100};
    tbv = '{7'd27, 7'd1, 7'd7, 7'd1};
    tsv = '{1'b0, 1'b0, 1'b1, 1'b1};
    es  = '{56'd127, 56'h80_0000_0000_0000, 56'hFF_FFFF_FFFF_FFFE, 56'hFF};
    ek  = '{1, 7, 7, 2};
    for (int i = 0; i < 4; i++) begin
      run_op(ta[i], tbv[i], tsv[i], s1, k1, s0, k0);
      checks += 4;
      if (s1 !== es[i]) begin errors++; $display("FAIL dir%0d_sum got %h want %h", i, s1, es[i]); end
      if (k1 != ek[i])  begin errors++; $display("FAIL dir%0d_lat got %0d want %0d", i, k1, ek[i]); end
      if (s0 !== es[i]) begin errors++; $display("FAIL dir%0d_sum_noexit got %h want %h", i, s0, es[i]); end
      if (k0 != 7)      begin errors++; $display("FAIL dir%0d_lat_noexit got %0d want 7", i, k0); end
    end
  endtask

  task automatic test_random;
    logic [AW-1:0] ra;
    logic [BW-1:0] rb;
    logic          rs;
    logic [AW:0]   s1, s0, es;
    int            k1, k0, ek;
    for (int i = 0; i < 40; i++) begin
      ra = AW'({$urandom(), $urandom()});
      case ($urandom_range(0, 3))
        0: ;
        1: ra = ra | AW'(64'h0000_FFFF_FFFF);
        2: ra = ra & AW'(64'h0000_0000_00FF);
        default: ra = ra & ~AW'(64'h0000_0000_00FF);
      endcase
      rb = BW'($urandom());
      rs = 1'($urandom());
      es = exp_sum(ra, rb, rs);
      ek = exp_k(ra, rb, rs);
      run_op(ra, rb, rs, s1, k1, s0, k0);
      checks += 4;
      if (s1 !== es)   begin errors++; $display("FAIL rnd%0d_sum a=%h b=%h sub=%b got %h want %h", i, ra, rb, rs, s1, es); end
      if (k1 != ek)    begin errors++; $display("FAIL rnd%0d_lat got %0d want %0d", i, k1, ek); end
      if (s0 !== es)   begin errors++; $display("FAIL rnd%0d_sum_noexit got %h want %h", i, s0, es); end
      if (k0 != NCHUNK) begin errors++; $display("FAIL rnd%0d_lat_noexit got %0d want %0d", i, k0, NCHUNK); end
    end
  endtask

  task automatic test_backpressure;
    @(negedge clk);
    a = 55'd100; b = 7'd27; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 0; c < 20 && !(out_valid1 && out_valid0); c++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (!(out_valid1 && out_valid0)) begin errors++; $display("FAIL bp_done_timeout got %b%b want 11", out_valid1, out_valid0); end
    @(negedge clk);
    a = 55'd1000; b = 7'd5; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks += 4;
      if (sum1 !== 56'd127)   begin errors++; $display("FAIL bp_hold_sum c%0d got %h want 7f", c, sum1); end
      if (in_ready1 !== 1'b0) begin errors++; $display("FAIL bp_hold_in_ready c%0d got %b want 0", c, in_ready1); end
      if (out_valid1 !== 1'b1) begin errors++; $display("FAIL bp_hold_out_valid c%0d got %b want 1", c, out_valid1); end
      if (in_ready0 !== 1'b0) begin errors++; $display("FAIL bp_hold_in_ready_noexit c%0d got %b want 0", c, in_ready0); end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks += 3;
    if (in_ready1 !== 1'b1)  begin errors++; $display("FAIL bp_idle_in_ready got %b want 1", in_ready1); end
    if (out_valid1 !== 1'b0) begin errors++; $display("FAIL bp_idle_out_valid got %b want 0", out_valid1); end
    if (sum1 !== 56'd127)    begin errors++; $display("FAIL bp_idle_sum got %h want 7f", sum1); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (in_ready1 !== 1'b0) begin errors++; $display("FAIL bp_accept got in_ready %b want 0", in_ready1); end
    @(posedge clk); #1;
    checks += 2;
    if (out_valid1 !== 1'b1) begin errors++; $display("FAIL bp_new_valid got %b want 1", out_valid1); end
    if (sum1 !== 56'd1005)   begin errors++; $display("FAIL bp_new_sum got %h want 3ed", sum1); end
    for (int c = 0; c < 30 && !(in_ready1 && in_ready0); c++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (!(in_ready1 && in_ready0)) begin errors++; $display("FAIL bp_drain_timeout got %b%b want 11", in_ready1, in_ready0); end
  endtask

  task automatic test_reset_mid_run;
    logic [AW:0] s1, s0;
    int          k1, k0;
    @(negedge clk);
    a = 55'h7F_FFFF_FFFF_FFFF; b = 7'd1; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    checks++;
    if (out_valid1 !== 1'b0) begin errors++; $display("FAIL mid_still_running got %b want 0", out_valid1); end
    #1 rst_n = 1'b0;
    #1;
    checks += 6;
    if (out_valid1 !== 1'b0) begin errors++; $display("FAIL mid_rst_out_valid got %b want 0", out_valid1); end
    if (sum1 !== '0)         begin errors++; $display("FAIL mid_rst_sum got %h want 0", sum1); end
    if (in_ready1 !== 1'b1)  begin errors++; $display("FAIL mid_rst_in_ready got %b want 1", in_ready1); end
    if (out_valid0 !== 1'b0) begin errors++; $display("FAIL mid_rst_out_valid_noexit got %b want 0", out_valid0); end
    if (sum0 !== '0)         begin errors++; $display("FAIL mid_rst_sum_noexit got %h want 0", sum0); end
    if (in_ready0 !== 1'b1)  begin errors++; $display("FAIL mid_rst_in_ready_noexit got %b want 1", in_ready0); end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(55'd1, 7'd1, 1'b0, s1, k1, s0, k0);
    checks += 4;
    if (s1 !== 56'd2) begin errors++; $display("FAIL post_rst_sum got %h want 2", s1); end
    if (k1 != 1)      begin errors++; $display("FAIL post_rst_lat got %0d want 1", k1); end
    if (s0 !== 56'd2) begin errors++; $display("FAIL post_rst_sum_noexit got %h want 2", s0); end
    if (k0 != 7)      begin errors++; $display("FAIL post_rst_lat_noexit got %0d want 7", k0); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
